// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and types: sample format and frame-buffer occupancy.
package fft_pkg;

    localparam int DW     = 16;
    localparam int NPT    = 16;
    localparam int NFRAME = 64;

    typedef logic signed [DW-1:0] sample_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_HALF  = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/fft_frame_buf.sv
// One half of the ping-pong store: NPT real + NPT imag words and the occupancy state.
module fft_frame_buf #(
    parameter int DW  = 16,
    parameter int NPT = 16,
    localparam int LW = $clog2(NPT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_re,
    input  logic              cap_im,
    input  logic              rel,
    input  logic [NPT*DW-1:0] fft_d,
    input  logic [LW-1:0]     lane,
    output fft_pkg::buf_state_t state,
    output logic [DW-1:0]     rd_re,
    output logic [DW-1:0]     rd_im
);
    import fft_pkg::BUF_EMPTY;
    import fft_pkg::BUF_HALF;
    import fft_pkg::BUF_FULL;

    logic [DW-1:0] re_mem [NPT];
    logic [DW-1:0] im_mem [NPT];

    // Sample storage is deliberately not reset; occupancy state guards its use.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NPT; k++) begin
            if (cap_re) re_mem[k] <= fft_d[k*DW +: DW];
            if (cap_im) im_mem[k] <= fft_d[k*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        state <= BUF_EMPTY;
        else if (rel)    state <= BUF_EMPTY;
        else if (cap_im) state <= BUF_FULL;
        else if (cap_re) state <= BUF_HALF;
    end

    assign rd_re = re_mem[lane];
    assign rd_im = im_mem[lane];

endmodule

// File: rtl/fft_out_serializer.sv
// Captures real/imag FFT frames into a ping-pong buffer and streams them out one
// complex point per cycle with a global bin index.
module fft_out_serializer #(
    parameter int DW     = fft_pkg::DW,
    parameter int NPT    = fft_pkg::NPT,
    parameter int NFRAME = fft_pkg::NFRAME,
    localparam int IW    = $clog2(NPT*NFRAME),
    localparam int LW    = $clog2(NPT),
    localparam int FW    = $clog2(NFRAME)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fftr_valid,
    input  logic              ffti_valid,
    input  logic [NPT*DW-1:0] fft_d,
    input  logic              done_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_re,
    output logic [DW-1:0]     out_im,
    output logic [IW-1:0]     out_idx,
    output logic              frame_done,
    output logic              all_done,
    output logic              err_ovf,
    output logic              err_seq
);
    import fft_pkg::buf_state_t;
    import fft_pkg::BUF_EMPTY;
    import fft_pkg::BUF_HALF;
    import fft_pkg::BUF_FULL;

    buf_state_t    st    [2];
    logic [DW-1:0] rd_re [2];
    logic [DW-1:0] rd_im [2];
    logic [1:0]    cap_re, cap_im, rel;

    logic          wp, rp;
    logic [LW-1:0] lane;
    logic [FW-1:0] frame_cnt;
    logic          drop_pend, pend_nxt, done_seen;
    logic          seq_hit, ovf_hit, accept, last;

    for (genvar b = 0; b < 2; b++) begin : g_buf
        fft_frame_buf #(.DW(DW), .NPT(NPT)) u_buf (
            .clk    (clk),
            .rst    (rst),
            .cap_re (cap_re[b]),
            .cap_im (cap_im[b]),
            .rel    (rel[b]),
            .fft_d  (fft_d),
            .lane   (lane),
            .state  (st[b]),
            .rd_re  (rd_re[b]),
            .rd_im  (rd_im[b])
        );
    end

    assign out_valid = (st[rp] == BUF_FULL);
    assign out_re    = out_valid ? rd_re[rp] : '0;
    assign out_im    = out_valid ? rd_im[rp] : '0;
    assign out_idx   = IW'(frame_cnt) * IW'(NPT) + IW'(lane);

    assign accept = out_valid && out_ready;
    assign last   = accept && (lane == LW'(NPT-1));

    // drop_pend swallows the imag strobe that belongs to an overflowed real frame.
    always_comb begin
        cap_re   = '0;
        cap_im   = '0;
        rel      = '0;
        seq_hit  = 1'b0;
        ovf_hit  = 1'b0;
        pend_nxt = drop_pend;
        rel[rp]  = last;
        if (fftr_valid && ffti_valid) begin
            seq_hit = 1'b1;
        end else if (fftr_valid) begin
            pend_nxt = 1'b0;
            case (st[wp])
                BUF_EMPTY: cap_re[wp] = 1'b1;
                BUF_HALF: begin
                    cap_re[wp] = 1'b1;
                    seq_hit    = 1'b1;
                end
                default: begin
                    ovf_hit  = 1'b1;
                    pend_nxt = 1'b1;
                end
            endcase
        end else if (ffti_valid) begin
            pend_nxt = 1'b0;
            if (!drop_pend) begin
                if (st[wp] == BUF_HALF) cap_im[wp] = 1'b1;
                else                    seq_hit    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp         <= 1'b0;
            rp         <= 1'b0;
            lane       <= '0;
            frame_cnt  <= '0;
            drop_pend  <= 1'b0;
            done_seen  <= 1'b0;
            frame_done <= 1'b0;
            all_done   <= 1'b0;
            err_ovf    <= 1'b0;
            err_seq    <= 1'b0;
        end else begin
            wp         <= wp ^ (|cap_im);
            rp         <= rp ^ last;
            drop_pend  <= pend_nxt;
            frame_done <= last;
            err_ovf    <= err_ovf | ovf_hit;
            err_seq    <= err_seq | seq_hit;
            done_seen  <= done_seen | done_in;
            all_done   <= all_done | (done_seen && st[0] == BUF_EMPTY && st[1] == BUF_EMPTY);
            if (accept) lane <= last ? '0 : lane + 1'b1;
            if (last) frame_cnt <= (frame_cnt == FW'(NFRAME-1)) ? '0 : frame_cnt + 1'b1;
        end
    end

endmodule

// File: doc/fft_out_serializer.md
# fft_out_serializer

Ping-pong frame buffer and serializer sitting downstream of the FFT core: it captures each 16-lane FFT result frame (a real frame on `fftr_valid`, then an imaginary frame on `ffti_valid`) and emits the 16 complex points one per cycle on a valid/ready stream with a global bin index. It is the consumer end of the FFT parallel output interface and decouples the bursty FFT output from narrow downstream logic (magnitude, analysis, host readout).

## Interface
- `DW`, 16: sample width, signed 8.8 fixed point, passed through unmodified
- `NPT`, 16: lanes per FFT output frame
- `NFRAME`, 64: frames per FFT run (1024 points total); sets index width `IW = $clog2(NPT*NFRAME)` = 10
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `fftr_valid`  in  1  single-cycle strobe: `fft_d` holds the real frame
- `ffti_valid`  in  1  single-cycle strobe: `fft_d` holds the imag frame
- `fft_d`  in  NPT*DW  frame data; lane k = `fft_d[k*DW +: DW]` (lane 0 = fft_d0)
- `done_in`  in  1  FFT core done; level or pulse
- `out_valid`  out  1  `out_re`/`out_im`/`out_idx` valid
- `out_ready`  in  1  downstream accepts when high with `out_valid`
- `out_re`, `out_im`  out  DW each  real/imag of current point
- `out_idx`  out  IW  global bin index = frame_no*NPT + lane
- `frame_done`  out  1  one-cycle pulse when last lane of a frame is accepted
- `all_done`  out  1  sticky: `done_in` seen, both buffers empty, nothing pending
- `err_ovf`  out  1  sticky: a frame was dropped (both buffers occupied)
- `err_seq`  out  1  sticky: strobe order violated

## Operation
- Two buffers B0/B1, each NPT real + NPT imag words, plus state per buffer: EMPTY, HALF (real captured), FULL. Write pointer `wp`, read pointer `rp`, both reset to B0.
- `fftr_valid`: if B[wp] EMPTY -> capture real, B[wp]=HALF. If B[wp] HALF -> overwrite real, set `err_seq`. If B[wp] FULL (both buffers occupied) -> drop, set `err_ovf`; the matching `ffti_valid` is also dropped silently.
- `ffti_valid`: if B[wp] HALF -> capture imag, B[wp]=FULL, `wp` toggles. If B[wp] EMPTY -> ignore, set `err_seq`.
- Both strobes in the same cycle: `err_seq`, both ignored.
- Output: while B[rp] FULL, present lane `lane` (0..NPT-1). Advance on `out_valid && out_ready`. After lane NPT-1 accepted: B[rp]=EMPTY, `rp` toggles, `frame_cnt` increments (wraps at NFRAME), `frame_done` pulses.
- A buffer freed and a new capture into the other buffer in the same cycle are both honoured. A freed buffer becomes writable the next cycle.
- `done_in` sets an internal flag; `all_done` rises when flag set, both buffers EMPTY. Cleared only by reset.
- Reset (any time, including mid-frame): all buffers EMPTY, pointers 0, lane/frame counters 0, all outputs 0, sticky flags cleared; buffer data contents need not be cleared.

## Timing
- Reset values: `out_valid`=0, `out_re`=`out_im`=0, `out_idx`=0, `frame_done`=0, `all_done`=0, `err_ovf`=0, `err_seq`=0.
- Latency: `out_valid` high the cycle after the edge that captures the imag frame (1 cycle). Outputs registered.
- Handshake: once `out_valid` is high, `out_re`/`out_im`/`out_idx` hold stable until accepted; `out_valid` never drops without acceptance.
- Throughput: 1 point/cycle with `out_ready` high; back-to-back frames gap-free (lane 15 of frame n followed next cycle by lane 0 of frame n+1).
- `frame_done` asserted in the cycle after the final acceptance; `all_done` no earlier than that cycle.

## Structure
- Package `fft_pkg`: `DW`, `NPT`, `NFRAME`, buffer-state enum (EMPTY/HALF/FULL), `sample_t` typedef; shared with the FFT core.
- One sub-module `fft_frame_buf`: single buffer (storage, state, capture logic), instantiated twice; serializer control in the top.

## Test plan
- Single frame, lanes real=k, imag=0x100+k, `out_ready`=1 -> 16 outputs idx 0..15, re=k, im=0x100+k, `frame_done` once, 1-cycle latency.
- Two frames back-to-back, `out_ready` toggling 1010… -> 32 points in order, idx 0..31, data stable while stalled.
- Three frames with `out_ready`=0 -> frames 0,1 held, frame 2 dropped, `err_ovf`=1; releasing ready yields exactly idx 0..31.
- `ffti_valid` without preceding `fftr_valid`, and two `fftr_valid` in a row -> `err_seq`=1, second real frame's data emitted.
- Full 64-frame run then `done_in` -> idx reaches 1023, `all_done`=1 after last `frame_done`, next frame wraps idx to 0.
- Reset asserted mid-stream at lane 7 -> all outputs 0 asynchronously; next frame starts at idx 0.
